// File: rtl/banco_pkg.sv
// Shared definitions for the banco register file: clear-FSM state type,
// default geometry and the address-width helper.
package banco_pkg;

  // Bulk-clear engine state.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Address width for a bank of 'depth' entries; never less than one bit.
  function automatic int addr_width(input int depth);
    if (depth > 2) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/banco_entry.sv
// One WIDTH-bit storage word of the register bank.
// Synchronous clear has priority over synchronous load; async active-low reset.
module banco_entry #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Next value: clear wins over load, otherwise hold.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = {WIDTH{1'b0}};
    end else if (en_i) begin
      data_d = d_i;
    end else begin
      data_d = data_q;
    end
  end

  // Storage flop with asynchronous reset to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= {WIDTH{1'b0}};
    end else begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/banco_reg_param.sv
// Parametrised register bank: WIDTH x DEPTH, two combinational read ports,
// one synchronous write port, optional hardwired-zero entry 0 and a
// one-entry-per-cycle bulk-clear engine with a busy flag.
// Build option: define BANCO_BYPASS_EN to forward WriteData to a read port
// addressing the entry being written in the same cycle.
module banco_reg_param
  import banco_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 0
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [addr_width(DEPTH)-1:0]   Read1,
  input  logic [addr_width(DEPTH)-1:0]   Read2,
  input  logic [addr_width(DEPTH)-1:0]   WriteReg,
  input  logic [WIDTH-1:0]               WriteData,
  input  logic                           RegWrite,
  input  logic                           clr_req,
  output logic [WIDTH-1:0]               Data1,
  output logic [WIDTH-1:0]               Data2,
  output logic                           busy
);

  localparam int AW = addr_width(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ZERO_IDX = {AW{1'b0}};

  state_e           state_q;
  state_e           state_d;
  logic [AW-1:0]    cnt_q;
  logic [AW-1:0]    cnt_d;
  logic             busy_q;
  logic             busy_d;

  logic             wr_ok_s;
  logic             clr_active_s;
  logic [DEPTH-1:0] wr_en_s;
  logic [DEPTH-1:0] clr_en_s;
  logic [WIDTH-1:0] bank_s [DEPTH];
  logic             byp1_s;
  logic             byp2_s;
  logic [WIDTH-1:0] data1_s;
  logic [WIDTH-1:0] data2_s;

  // Clear-engine state, sweep counter and busy flag registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= {AW{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: start a sweep on clr_req, finish after the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = {AW{1'b0}};
        end else begin
          state_d = IDLE;
          cnt_d   = cnt_q;
        end
      end
      CLEAR: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = {AW{1'b0}};
        end else begin
          state_d = CLEAR;
          cnt_d   = cnt_q + AW'(1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {AW{1'b0}};
      end
    endcase
  end

  // Outputs of the engine: write qualification, sweep enable, next busy.
  always_comb begin
    wr_ok_s      = 1'b0;
    clr_active_s = 1'b0;
    busy_d       = (state_d == CLEAR);
    case (state_q)
      IDLE: begin
        if ((ZERO_REG != 0) && (WriteReg == ZERO_IDX)) begin
          wr_ok_s = 1'b0;
        end else begin
          wr_ok_s = RegWrite;
        end
        clr_active_s = 1'b0;
      end
      CLEAR: begin
        wr_ok_s      = 1'b0;
        clr_active_s = 1'b1;
      end
      default: begin
        wr_ok_s      = 1'b0;
        clr_active_s = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign wr_en_s[i]  = wr_ok_s && (WriteReg == AW'(i));
    assign clr_en_s[i] = clr_active_s && (cnt_q == AW'(i));

    banco_entry #(
      .WIDTH (WIDTH)
    ) u_entry (
      .clk_i  (clock),
      .rst_ni (reset_n),
      .en_i   (wr_en_s[i]),
      .clr_i  (clr_en_s[i]),
      .d_i    (WriteData),
      .q_o    (bank_s[i])
    );
  end

  // Same-cycle forwarding hits for each read port.
  always_comb begin
`ifdef BANCO_BYPASS_EN
    byp1_s = wr_ok_s && (WriteReg == Read1);
    byp2_s = wr_ok_s && (WriteReg == Read2);
`else
    byp1_s = 1'b0;
    byp2_s = 1'b0;
`endif
  end

  // Read port 1: hardwired zero, then forwarding, then stored value.
  always_comb begin
    data1_s = {WIDTH{1'b0}};
    if ((ZERO_REG != 0) && (Read1 == ZERO_IDX)) begin
      data1_s = {WIDTH{1'b0}};
    end else if (byp1_s) begin
      data1_s = WriteData;
    end else begin
      data1_s = bank_s[Read1];
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    data2_s = {WIDTH{1'b0}};
    if ((ZERO_REG != 0) && (Read2 == ZERO_IDX)) begin
      data2_s = {WIDTH{1'b0}};
    end else if (byp2_s) begin
      data2_s = WriteData;
    end else begin
      data2_s = bank_s[Read2];
    end
  end

  assign Data1 = data1_s;
  assign Data2 = data2_s;

endmodule

// File: tb/tb_banco_reg_param.sv
// Self-checking bench for banco_reg_param: a plain-array reference model
// (one for the ordinary build, one with hardwired-zero entry 0) is updated
// on each rising edge and compared with both DUT instances mid-cycle.
module tb_banco_reg_param;

  localparam int W = 8;
  localparam int D = 8;
  localparam int A = 3;

  logic         clock;
  logic         reset_n;
  logic [A-1:0] Read1, Read2, WriteReg;
  logic [W-1:0] WriteData;
  logic         RegWrite, clr_req;
  logic [W-1:0] Data1, Data2, Data1_z, Data2_z;
  logic         busy, busy_z;

  int checks;
  int failures;

  // Reference model state
  logic [W-1:0] m  [D];
  logic [W-1:0] mz [D];
  int clr_left;
  int clr_idx;

  banco_reg_param #(.WIDTH(W), .DEPTH(D), .ZERO_REG(0)) dut (
    .clock(clock), .reset_n(reset_n), .Read1(Read1), .Read2(Read2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .clr_req(clr_req), .Data1(Data1), .Data2(Data2), .busy(busy)
  );

  banco_reg_param #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut_z (
    .clock(clock), .reset_n(reset_n), .Read1(Read1), .Read2(Read2),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .clr_req(clr_req), .Data1(Data1_z), .Data2(Data2_z), .busy(busy_z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m[i]  = '0;
      mz[i] = '0;
    end
    clr_left = 0;
    clr_idx  = 0;
  endtask

  // Effect of one rising edge, from the behavioural rules.
  task automatic model_edge();
    if (reset_n) begin
      if (clr_left == 0) begin
        if (RegWrite) begin
          m[WriteReg] = WriteData;
          if (WriteReg != 0) mz[WriteReg] = WriteData;
        end
        if (clr_req) begin
          clr_left = D;
          clr_idx  = 0;
        end
      end else begin
        m[clr_idx]  = '0;
        mz[clr_idx] = '0;
        clr_idx  = clr_idx + 1;
        clr_left = clr_left - 1;
      end
    end
  endtask

  function automatic logic [W-1:0] exp_rd(input logic [A-1:0] addr, input bit z);
    if (z && addr == 0) return '0;
`ifdef BANCO_BYPASS_EN
    if (reset_n && RegWrite && clr_left == 0 && WriteReg == addr) return WriteData;
`endif
    return z ? mz[addr] : m[addr];
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s t=%0t observed=%h expected=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".d1"},   Data1,   exp_rd(Read1, 1'b0));
    chk({tag, ".d2"},   Data2,   exp_rd(Read2, 1'b0));
    chk({tag, ".d1z"},  Data1_z, exp_rd(Read1, 1'b1));
    chk({tag, ".d2z"},  Data2_z, exp_rd(Read2, 1'b1));
    chk({tag, ".busy"},  W'(busy),   W'(clr_left > 0));
    chk({tag, ".busyz"}, W'(busy_z), W'(clr_left > 0));
  endtask

  // Check mid-cycle, then take the rising edge in DUT and model.
  task automatic step(input string tag);
    @(negedge clock);
    check_all(tag);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    Read1 = '0; Read2 = '0; WriteReg = '0; WriteData = '0;
    RegWrite = 1'b0; clr_req = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    Read1 = 3'd5; Read2 = 3'd7;
    #1;
    check_all("reset_rd");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // 1: write 0xA5 to r3, read on both ports
    RegWrite = 1'b1; WriteReg = 3'd3; WriteData = 8'hA5; Read1 = 3'd3; Read2 = 3'd3;
    step("t1_wr");
    RegWrite = 1'b0;
    step("t1_rd");
    chk("t1_d1_const", Data1, 8'hA5);
    chk("t1_d2_const", Data2, 8'hA5);

    // 2: fill r(i)=i+0x10 then read through both ports
    for (int i = 0; i < D; i++) begin
      RegWrite = 1'b1; WriteReg = A'(i); WriteData = W'(i + 16);
      step("t2_wr");
    end
    RegWrite = 1'b0;
    for (int i = 0; i < D; i++) begin
      Read1 = A'(i); Read2 = A'(D - 1 - i);
      step("t2_rd");
    end

    // 3: same-cycle write/read of r5
    RegWrite = 1'b1; WriteReg = 3'd5; WriteData = 8'h3C; Read1 = 3'd5; Read2 = 3'd0;
    step("t3_same");
    RegWrite = 1'b0;
    step("t3_next");
    chk("t3_next_const", Data1, 8'h3C);

    // 4: fill with 0xFF, sweep, writes during busy are lost
    for (int i = 0; i < D; i++) begin
      RegWrite = 1'b1; WriteReg = A'(i); WriteData = 8'hFF;
      step("t4_fill");
    end
    RegWrite = 1'b0; clr_req = 1'b1;
    step("t4_req");
    clr_req = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      RegWrite = 1'($urandom_range(0, 1)); WriteReg = A'($urandom_range(0, D - 1));
      WriteData = W'($urandom); clr_req = 1'($urandom_range(0, 1));
      Read1 = A'($urandom_range(0, D - 1)); Read2 = A'($urandom_range(0, D - 1));
      step("t4_busy");
    end
    chk("t4_busy_len", W'(n), W'(D));
    RegWrite = 1'b0; clr_req = 1'b0;
    for (int i = 0; i < D; i++) begin
      Read1 = A'(i); Read2 = A'(i);
      step("t4_zero");
      chk("t4_zero_const", Data1, 8'h00);
    end

    // 5: clr_req and write r2=0x77 on the same edge
    RegWrite = 1'b1; WriteReg = 3'd2; WriteData = 8'h77; clr_req = 1'b1; Read1 = 3'd2; Read2 = 3'd2;
    step("t5_req");
    RegWrite = 1'b0; clr_req = 1'b0;
    step("t5_after");
    chk("t5_seen", Data1, 8'h77);
    for (int i = 0; i < D; i++) step("t5_sweep");
    chk("t5_cleared", Data1, 8'h00);

    // 6: reset in the middle of a sweep
    for (int i = 0; i < D; i++) begin
      RegWrite = 1'b1; WriteReg = A'(i); WriteData = W'($urandom_range(1, 255));
      step("t6_fill");
    end
    RegWrite = 1'b0; clr_req = 1'b1;
    step("t6_req");
    clr_req = 1'b0;
    for (int i = 0; i < 3; i++) step("t6_busy");
    Read1 = 3'd6; Read2 = 3'd7;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("t6_rst");
    chk("t6_busy_const", W'(busy), 8'h00);
    #1;
    reset_n = 1'b1;
    RegWrite = 1'b1; WriteReg = 3'd6; WriteData = 8'h5A;
    step("t6_wr");
    RegWrite = 1'b0;
    step("t6_rd");
    chk("t6_rd_const", Data1, 8'h5A);

    // 7: random traffic
    for (int i = 0; i < 400; i++) begin
      RegWrite  = 1'($urandom_range(0, 1));
      WriteReg  = A'($urandom_range(0, D - 1));
      WriteData = W'($urandom);
      clr_req   = ($urandom_range(0, 29) == 0);
      Read1     = ($urandom_range(0, 3) == 0) ? WriteReg : A'($urandom_range(0, D - 1));
      Read2     = A'($urandom_range(0, D - 1));
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
